key_matrix_scanner: RTL
=======================

KEY_MATRIX_SCANNER -- requirements
Module: key_matrix_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 100000: clk_100M cycles per row-scan tick (1 ms).
REQ-002 Parameter DEBOUNCE_FRAMES, default 4: consecutive identical frames needed to accept a press or release.
REQ-003 Parameter REPEAT_DELAY, default 100: frames from press event to first repeat.
REQ-004 Parameter REPEAT_RATE, default 20: frames between subsequent repeats.
REQ-005 clk_100M  input  1  system clock; all logic in this domain.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 row_oe  output  5  one-hot row drive enable; the top level drives 0 on enabled rows and high-Z elsewhere.
REQ-008 col_n  input  5  column sense, pulled up; 0 means pressed on the driven row; asynchronous.
REQ-009 key_code  output  6  FIFO head: [5] = release flag, [4:0] = row*5+col (0..24).
REQ-010 key_valid  output  1  FIFO non-empty.
REQ-011 key_pop  input  1  consumer acknowledge; pops the head when key_valid=1, ignored otherwise.
REQ-012 overflow  output  1  sticky: an event was dropped because the FIFO was full.
REQ-013 ovf_clr  input  1  clears overflow.

Function
REQ-014 col_n shall pass through a 2-flop synchronizer before any use.
REQ-015 Divider shall pulse tick once every SCAN_DIV cycles; a 3-bit row index shall advance 0..4 on each tick and wrap 4->0.
REQ-016 On each tick, before advancing, the synchronized ~col_n shall be latched into the frame image for the current row; row_oe = 1<<row.
REQ-017 A frame completes on the tick that latches row 4; classification: none (0 bits set), single (exactly 1 bit set, code = row*5+col), multi (>=2 bits set).
REQ-018 Multi frames shall be treated as none for detection, so that ghosting combinations never produce a press.
REQ-019 FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB; it evaluates only at frame completion.
REQ-020 IDLE: single -> PRESS_DB with cand=code, cnt=1.
REQ-021 PRESS_DB: single with code==cand -> cnt+1; on reaching DEBOUNCE_FRAMES -> HELD and push {0,cand}; any other frame -> IDLE.
REQ-022 HELD: single with code==cand stays; any other frame -> RELEASE_DB with cnt=1.
REQ-023 RELEASE_DB: not (single with code==cand) -> cnt+1; on reaching DEBOUNCE_FRAMES -> IDLE and push {1,cand}; same-key frame -> HELD with no event.
REQ-024 FIFO: 4 entries, first-word fall-through; key_code is 6'h00 when empty.
REQ-025 Push while full shall drop the new event and set overflow; the stored contents shall be unchanged.
REQ-026 Simultaneous push and pop while full shall accept both, with no overflow.
REQ-027 Pop latency: key_valid and key_code shall update in the cycle after key_pop.
REQ-028 ovf_clr coincident with an overflow-setting push shall leave overflow=1.

Reset
REQ-029 rst shall clear the divider, row=0 (row_oe=5'b00001), frame image, FSM=IDLE, counters, FIFO (key_valid=0, key_code=0) and overflow=0.
REQ-030 rst asserted mid-debounce or mid-hold shall abandon the key with no release event.

Configuration
REQ-031 Macro KEY_MATRIX_SCANNER_REPEAT_EN defined: in HELD, push {0,cand} after REPEAT_DELAY frames, then every REPEAT_RATE frames; the repeat counter resets on entry to HELD and on return from RELEASE_DB.
REQ-032 Macro undefined: no repeat logic is built; exactly one press event per accepted hold.

Structure
REQ-033 Shared package key_pkg holds the FSM state enum, ROWS=5, COLS=5, the code width of 6 and the bit index of the release flag.
REQ-034 Sub-module key_event_fifo (4x6, FWFT, with full/empty outputs) shall be instantiated once.

Verification
All scenarios use SCAN_DIV=4, DEBOUNCE_FRAMES=2, REPEAT_DELAY=3, REPEAT_RATE=2.
REQ-035 Hold row 2 / col 3 for 4 frames, then release for 2 frames -> events 6'h0D then 6'h2D, key_valid set after frame 2 of the press.
REQ-036 A 1-frame glitch on row 1 / col 1 -> no event; FSM back in IDLE.
REQ-037 Hold keys (0,0) and (0,1) together -> no event; then release (0,1) -> press 6'h00 after 2 frames.
REQ-038 Five press/release pairs with no pops -> first 4 events kept, overflow=1; ovf_clr -> overflow=0.
REQ-039 REPEAT_EN build: hold (4,4) for 8 frames -> 6'h18 pushed at hold frames 0, 3 and 5; non-REPEAT build -> one 6'h18 only.
REQ-040 Assert rst during PRESS_DB and during HELD -> all outputs at reset values, no event after release.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and constants for the 5x5 key matrix scanner and its event FIFO.
package key_pkg;

  localparam int ROWS       = 5;
  localparam int COLS       = 5;
  localparam int NUM_KEYS   = ROWS * COLS;
  localparam int KEY_W      = 5;
  localparam int CODE_W     = 6;
  localparam int REL_BIT    = 5;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } key_state_e;

  typedef enum logic [1:0] {
    FRAME_NONE,
    FRAME_SINGLE,
    FRAME_MULTI
  } frame_kind_e;

  function automatic logic [CODE_W-1:0] make_code(input logic rel, input logic [KEY_W-1:0] key);
    make_code          = '0;
    make_code[REL_BIT] = rel;
    make_code[KEY_W-1:0] = key;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// First-word fall-through event FIFO; the head reads as zero while empty.
module key_event_fifo
  import key_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = CODE_W
) (
  input  logic             clk_100M,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is not reset; the empty flag masks stale data on the output.
  always_ff @(posedge clk_100M) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/key_matrix_scanner.sv
// 5x5 key matrix scanner with debounce, ghost rejection and an event FIFO.
// Define KEY_MATRIX_SCANNER_REPEAT_EN to build the auto-repeat generator.
module key_matrix_scanner
  import key_pkg::*;
#(
  parameter int SCAN_DIV        = 100000,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_DELAY    = 100,
  parameter int REPEAT_RATE     = 20
) (
  input  logic              clk_100M,
  input  logic              rst,
  output logic [ROWS-1:0]   row_oe,
  input  logic [COLS-1:0]   col_n,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_pop,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DB_W  = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int HIT_W = $clog2(NUM_KEYS + 1);

  // The synchronizer needs a few cycles per row to see the settled columns.
  if (SCAN_DIV < 4 || DEBOUNCE_FRAMES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_cfg_check
    $error("key_matrix_scanner: unsupported parameter set");
  end

  logic [COLS-1:0]     col_meta_q, col_sync_q;
  logic [DIV_W-1:0]    div_q;
  logic [2:0]          row_q;
  logic [NUM_KEYS-1:0] frame_q, frame_now;
  logic                tick, frame_done;

  logic [HIT_W-1:0]    hit_cnt;
  logic [KEY_W-1:0]    hit_code;
  frame_kind_e         kind;
  logic                same_key;

  key_state_e          state_q, state_d;
  logic [KEY_W-1:0]    cand_q, cand_d;
  logic [DB_W-1:0]     cnt_q, cnt_d;
  logic                db_done;

  logic                push, rpt_fire;
  logic [CODE_W-1:0]   push_code;
  logic                fifo_full, fifo_empty;
  logic                overflow_q;

  assign tick       = (div_q == DIV_W'(SCAN_DIV - 1));
  assign frame_done = tick && (row_q == 3'(ROWS - 1));
  assign row_oe     = ROWS'(1) << row_q;

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      col_meta_q <= '1;
      col_sync_q <= '1;
      div_q      <= '0;
      row_q      <= '0;
      frame_q    <= '0;
    end else begin
      col_meta_q <= col_n;
      col_sync_q <= col_meta_q;
      div_q      <= tick ? '0 : div_q + DIV_W'(1);
      if (tick) begin
        row_q   <= (row_q == 3'(ROWS - 1)) ? 3'd0 : row_q + 3'd1;
        frame_q <= frame_now;
      end
    end
  end

  // Classification sees the row being latched this tick, so a frame is judged whole.
  // NOTE: every always_comb assigns defaults first so no latch is inferred.
  always_comb begin
    frame_now = frame_q;
    frame_now[row_q*COLS +: COLS] = ~col_sync_q;
    hit_cnt  = '0;
    hit_code = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (frame_now[i]) begin
        hit_cnt  = hit_cnt + HIT_W'(1);
        hit_code = KEY_W'(i);
      end
    end
    if (hit_cnt == '0)              kind = FRAME_NONE;
    else if (hit_cnt == HIT_W'(1))  kind = FRAME_SINGLE;
    else                            kind = FRAME_MULTI;
  end

  // Multi-key frames never match a candidate, which is what suppresses ghosts.
  assign same_key = (kind == FRAME_SINGLE) && (hit_code == cand_q);
  assign db_done  = (int'(cnt_q) + 1 >= DEBOUNCE_FRAMES);

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    if (frame_done) begin
      case (state_q)
        IDLE: begin
          if (kind == FRAME_SINGLE) begin
            state_d = PRESS_DB;
            cand_d  = hit_code;
            cnt_d   = DB_W'(1);
          end
        end
        PRESS_DB: begin
          if (!same_key)    state_d = IDLE;
          else if (db_done) state_d = HELD;
          else              cnt_d   = cnt_q + DB_W'(1);
        end
        HELD: begin
          if (!same_key) begin
            state_d = RELEASE_DB;
            cnt_d   = DB_W'(1);
          end
        end
        RELEASE_DB: begin
          if (same_key)     state_d = HELD;
          else if (db_done) state_d = IDLE;
          else              cnt_d   = cnt_q + DB_W'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    push      = 1'b0;
    push_code = '0;
    if (frame_done) begin
      case (state_q)
        PRESS_DB: begin
          if (same_key && db_done) begin
            push      = 1'b1;
            push_code = make_code(1'b0, cand_q);
          end
        end
        HELD: begin
          if (rpt_fire) begin
            push      = 1'b1;
            push_code = make_code(1'b0, cand_q);
          end
        end
        RELEASE_DB: begin
          if (!same_key && db_done) begin
            push      = 1'b1;
            push_code = make_code(1'b1, cand_q);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef KEY_MATRIX_SCANNER_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_phase_q, rpt_phase_d;

  // Any frame that is not a same-key hold rearms the initial delay.
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_phase_d = rpt_phase_q;
    rpt_fire    = 1'b0;
    if (frame_done) begin
      if (state_q == HELD && same_key) begin
        if (int'(rpt_cnt_q) + 1 == (rpt_phase_q ? REPEAT_RATE : REPEAT_DELAY)) begin
          rpt_fire    = 1'b1;
          rpt_cnt_d   = '0;
          rpt_phase_d = 1'b1;
        end else begin
          rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
        end
      end else begin
        rpt_cnt_d   = '0;
        rpt_phase_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      rpt_cnt_q   <= '0;
      rpt_phase_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_phase_q <= rpt_phase_d;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .clk_100M    (clk_100M),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_code),
    .pop_i       (key_pop),
    .data_o      (key_code),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign key_valid = !fifo_empty;

  // A set request wins over a coincident clear so no drop goes unreported.
  always_ff @(posedge clk_100M) begin
    if (rst)                              overflow_q <= 1'b0;
    else if (push && fifo_full && !key_pop) overflow_q <= 1'b1;
    else if (ovf_clr)                     overflow_q <= 1'b0;
  end

  assign overflow = overflow_q;

endmodule
